// File: rtl/inst_fetch_unit_if.sv
// Shared types for the fetch path and the instruction-memory bus interface.
// The fetch unit sits on the master side of the bus; memory is the slave.

package sys;
  localparam int ADDR_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

package core;
  localparam int INST_W = 32;
  typedef logic [INST_W-1:0] inst_t;

  typedef struct packed {
    sys::addr_t pc;
    logic       en;
  } inst_fetch_req_t;

  typedef struct packed {
    inst_t inst;
    logic  done;
  } inst_fetch_rsp_t;
endpackage

interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [INST_W-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Single-outstanding instruction fetch unit with a one-entry line buffer.
// The buffer holds the last fetched {pc, inst} so done stays high while the
// fetch stage stalls on the same PC. Responses for a PC that is no longer
// requested (redirect or enable drop) are dropped and counted.

module inst_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  core::inst_fetch_req_t inst_fetch_req,
  output core::inst_fetch_rsp_t inst_fetch_rsp,
  inst_fetch_unit_if.master     bus,
  output logic [CNT_W-1:0]      stale_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_pc;
  logic [INST_W-1:0] buf_inst;
  logic [ADDR_W-1:0] req_addr;

  logic hit;
  logic rsp_match;

  // Full-PC compare: an unaligned PC is a distinct key from its aligned word.
  assign hit       = inst_fetch_req.en && buf_valid && (buf_pc == inst_fetch_req.pc);
  assign rsp_match = inst_fetch_req.en && (inst_fetch_req.pc == req_addr);

  // Fetch-stage response is purely a buffer lookup; zero-cycle hit latency.
  assign inst_fetch_rsp.done = hit;
  assign inst_fetch_rsp.inst = hit ? buf_inst : '0;

  // Bus request is a decode of the state register, so it stays stable until
  // the handshake; req_addr is frozen while in REQ.
  assign bus.mem_req_valid = (state == REQ);
  assign bus.mem_req_addr  = (state == REQ) ? {req_addr[ADDR_W-1:2], 2'b00} : '0;

  // Fetch FSM, line buffer and stale counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_inst  <= '0;
      req_addr  <= '0;
      stale_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_fetch_req.en && !hit) begin
            req_addr <= inst_fetch_req.pc;
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (rsp_match) begin
              buf_valid <= 1'b1;
              buf_pc    <= req_addr;
              buf_inst  <= bus.mem_rsp_data;
              state     <= IDLE;
            end else begin
              if (stale_cnt != '1) stale_cnt <= stale_cnt + CNT_W'(1);
              if (inst_fetch_req.en) begin
                req_addr <= inst_fetch_req.pc;
                state    <= REQ;
              end else begin
                state    <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: behavioral memory with programmable latency,
// expected instructions queued when a fetch PC is driven and popped on done.

module tb_inst_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core::inst_fetch_req_t req;
  core::inst_fetch_rsp_t rsp;
  logic [1:0]            stale_cnt;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(.CNT_W(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_fetch_req (req),
    .inst_fetch_rsp (rsp),
    .bus            (bus),
    .stale_cnt      (stale_cnt)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // Memory model state.
  logic        rdy = 1'b1;
  logic        rsp_spur = 1'b0;
  logic        pend = 1'b0;
  int          cnt = 0;
  int          lat = 1;
  logic [31:0] paddr = '0;

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : {~a[15:0], a[15:0]};
  endfunction

  assign bus.mem_req_ready = rdy;
  assign bus.mem_rsp_valid = rsp_spur | (pend && cnt == 0);
  assign bus.mem_rsp_data  = rsp_spur ? 32'hDEAD_BEEF : mem_data(paddr);

  // Memory: accept on handshake, answer lat cycles later for one cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else begin
      if (pend) begin
        if (cnt == 0) pend <= 1'b0;
        else          cnt  <= cnt - 1;
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= bus.mem_req_addr;
      end
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(logic [31:0] a);
    exp_q.push_back(mem_data(a));
  endtask

  // Wait for done (bounded), check latency and pop the expected instruction.
  task automatic done_chk(string tag, int lat_exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp.done && n < 64);
    chk({tag, "_lat"}, n, lat_exp);
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
    else chk({tag, "_inst"}, rsp.inst, exp_q.pop_front());
  endtask

  task automatic wait_hs();
    int n = 0;
    while (!(bus.mem_req_valid && bus.mem_req_ready) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk("hs_timeout", 0, 1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!bus.mem_rsp_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req      = '0;
    rst_n    = 1'b0;
    rsp_spur = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.mem_req_valid, 0);
    chk("rst_addr",  bus.mem_req_addr, 0);
    chk("rst_done",  rsp.done, 0);
    chk("rst_inst",  rsp.inst, 0);
    chk("rst_stale", stale_cnt, 0);
    rsp_spur = 1'b0;
    rst_n    = 1'b1;

    // Miss then hold.
    req.pc = 32'h100;
    req.en = 1'b1;
    push_exp(32'h100);
    @(negedge clk);
    chk("miss_valid", bus.mem_req_valid, 1);
    chk("miss_addr",  bus.mem_req_addr, 32'h100);
    done_chk("miss", 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_done",  rsp.done, 1);
      chk("hold_noreq", bus.mem_req_valid, 0);
    end

    // Spurious response in IDLE.
    rsp_spur = 1'b1;
    @(negedge clk);
    rsp_spur = 1'b0;
    @(negedge clk);
    chk("spur_stale", stale_cnt, 0);
    chk("spur_done",  rsp.done, 1);
    chk("spur_inst",  rsp.inst, 32'h0050_0093);

    // Back-pressure: ready low for 4 cycles.
    rdy    = 1'b0;
    req.pc = 32'h200;
    push_exp(32'h200);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.mem_req_valid, 1);
      chk("bp_addr",  bus.mem_req_addr, 32'h200);
    end
    rdy = 1'b1;
    done_chk("bp", 2);

    // Redirect during WAIT.
    lat    = 2;
    req.pc = 32'h300;
    wait_hs();
    @(negedge clk);
    req.pc = 32'h400;
    push_exp(32'h400);
    wait_rsp();
    @(negedge clk);
    chk("redir_valid", bus.mem_req_valid, 1);
    chk("redir_addr",  bus.mem_req_addr, 32'h400);
    chk("redir_stale", stale_cnt, 1);
    chk("redir_done",  rsp.done, 0);
    done_chk("redir", 3);
    req.pc = 32'h300;
    #1;
    chk("redir_old_nohit", rsp.done, 0);
    req.pc = 32'h400;
    #1;
    chk("redir_hit", rsp.done, 1);
    chk("redir_hit_inst", rsp.inst, mem_data(32'h400));

    // Enable drop during WAIT.
    @(negedge clk);
    req.pc = 32'h500;
    push_exp(32'h500);
    wait_hs();
    @(negedge clk);
    req.en = 1'b0;
    wait_rsp();
    @(negedge clk);
    chk("drop_stale", stale_cnt, 2);
    chk("drop_valid", bus.mem_req_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_noreq", bus.mem_req_valid, 0);
      chk("drop_done",  rsp.done, 0);
    end
    req.en = 1'b1;
    done_chk("drop", 4);

    // Mid-run reset clears buffer and counter.
    @(negedge clk);
    rst_n  = 1'b0;
    req.en = 1'b0;
    @(negedge clk);
    chk("rst2_stale", stale_cnt, 0);
    chk("rst2_valid", bus.mem_req_valid, 0);
    rst_n  = 1'b1;
    req.pc = 32'h100;
    req.en = 1'b1;
    #1;
    chk("rst2_buf_clr", rsp.done, 0);
    req.pc = 32'h1000;

    // Saturating stale counter: five redirects in a row.
    for (int i = 0; i < 5; i++) begin
      wait_hs();
      @(negedge clk);
      req.pc = 32'h1000 + 32'(16 * (i + 1));
      wait_rsp();
      @(negedge clk);
      chk("sat_stale", stale_cnt, (i < 2) ? i + 1 : 3);
    end
    push_exp(32'h1050);
    done_chk("sat_fin", 3);
    chk("sat_hold", stale_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
